// File: rtl/gcbp_line_sched.sv
// Per-line scheduler: issues one engine start per new line inside the row window,
// then tracks completion, timeout, overrun and end-of-frame.
module gcbp_line_sched #(
    parameter int LINE_W      = 10,
    parameter int ROI_START   = 16,
    parameter int ROI_END     = 463,
    parameter int ENG_TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic [LINE_W-1:0] i_line_cnt,
    input  logic              i_enable,
    input  logic              i_eng_done,
    output logic              o_eng_start,
    output logic [LINE_W-1:0] o_eng_line,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overrun,
    output logic [7:0]        o_overrun_cnt,
    output logic              o_timeout
);

    localparam int                TMR_W    = $clog2(ENG_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ENG_TIMEOUT - 1);
    localparam logic [LINE_W-1:0] ROI_LO   = LINE_W'(ROI_START);
    localparam logic [LINE_W-1:0] ROI_HI   = LINE_W'(ROI_END);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   prev_line_q, prev_line_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                start_q, start_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                busy_q, busy_d;
    logic                frame_q, frame_d;
    logic                ovr_q, ovr_d;
    logic [7:0]          ovr_cnt_q, ovr_cnt_d;
    logic                tmo_q, tmo_d;

    logic ev;
    logic in_roi;
    logic ev_roi;
    logic finish;
    logic drop;

    assign ev     = (i_line_cnt != prev_line_q);
    assign in_roi = (i_line_cnt >= ROI_LO) && (i_line_cnt <= ROI_HI);
    assign ev_roi = ev && in_roi;

    always_comb begin
        state_d     = state_q;
        prev_line_d = i_line_cnt;
        timer_d     = timer_q;
        start_d     = 1'b0;
        line_d      = line_q;
        frame_d     = 1'b0;
        ovr_d       = 1'b0;
        ovr_cnt_d   = ovr_cnt_q;
        tmo_d       = 1'b0;
        finish      = 1'b0;
        drop        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (ev_roi) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    line_d  = i_line_cnt;
                end
            end
            S_START: begin
                state_d = S_RUN;
                timer_d = '0;
                drop    = ev_roi;
            end
            S_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                if (i_eng_done) begin
                    finish = 1'b1;
                    // A line arriving with done chains straight into the next start.
                    if (ev_roi && i_enable) begin
                        state_d = S_START;
                        start_d = 1'b1;
                        line_d  = i_line_cnt;
                    end else begin
                        state_d = i_enable ? S_ARMED : S_IDLE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    finish  = 1'b1;
                    tmo_d   = 1'b1;
                    drop    = ev_roi;
                    state_d = i_enable ? S_ARMED : S_IDLE;
                end else begin
                    drop = ev_roi;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // frame_done refers to the line just finished, not one being chained in.
        frame_d = finish && (line_q == ROI_HI);
        if (drop) begin
            ovr_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
        busy_d = (state_d == S_START) || (state_d == S_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q     <= S_IDLE;
            prev_line_q <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            line_q      <= '0;
            busy_q      <= 1'b0;
            frame_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ovr_cnt_q   <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_line_q <= prev_line_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            frame_q     <= frame_d;
            ovr_q       <= ovr_d;
            ovr_cnt_q   <= ovr_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign o_eng_start   = start_q;
    assign o_eng_line    = line_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = frame_q;
    assign o_overrun     = ovr_q;
    assign o_overrun_cnt = ovr_cnt_q;
    assign o_timeout     = tmo_q;

endmodule

// File: tb/tb_gcbp_line_sched.sv
// Bench for gcbp_line_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a job-level reference model.
module tb_gcbp_line_sched;

    localparam int LINE_W    = 10;
    localparam int ROI_START = 16;
    localparam int ROI_END   = 463;
    localparam int TMO       = 64;

    logic              i_clk = 1'b0;
    logic              i_resetn;
    logic [LINE_W-1:0] i_line_cnt;
    logic              i_enable;
    logic              i_eng_done;
    logic              o_eng_start;
    logic [LINE_W-1:0] o_eng_line;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_overrun;
    logic [7:0]        o_overrun_cnt;
    logic              o_timeout;

    gcbp_line_sched #(
        .LINE_W(LINE_W), .ROI_START(ROI_START), .ROI_END(ROI_END), .ENG_TIMEOUT(TMO)
    ) dut (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_line_cnt(i_line_cnt),
        .i_enable(i_enable), .i_eng_done(i_eng_done),
        .o_eng_start(o_eng_start), .o_eng_line(o_eng_line), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_overrun(o_overrun),
        .o_overrun_cnt(o_overrun_cnt), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: a job is either pending (not busy) or in flight with an age
    // counting posedges since its start pulse; age 0 is the start cycle.
    bit m_valid = 0;
    bit m_armed, m_busy;
    int m_age, m_prev;
    int e_line, e_cnt;
    bit e_start, e_frame, e_ovr, e_to;

    always @(posedge i_clk) begin
        int  lc;
        bit  ev, roi, ovr;
        if (!i_resetn) begin
            m_valid = 1; m_armed = 0; m_busy = 0; m_age = 0; m_prev = 0;
            e_line = 0; e_cnt = 0; e_start = 0; e_frame = 0; e_ovr = 0; e_to = 0;
        end else begin
            lc  = int'(i_line_cnt);
            ev  = (lc != m_prev);
            roi = (lc >= ROI_START) && (lc <= ROI_END);
            ovr = 0;
            e_start = 0; e_frame = 0; e_ovr = 0; e_to = 0;
            if (!m_busy) begin
                if (!m_armed) m_armed = i_enable;
                else if (!i_enable) m_armed = 0;
                else if (ev && roi) begin
                    m_busy = 1; m_age = 0; e_start = 1; e_line = lc;
                end
            end else if (m_age == 0) begin
                m_age = 1;
                ovr = ev && roi;
            end else if (i_eng_done || m_age == TMO) begin
                e_to    = !i_eng_done;
                e_frame = (e_line == ROI_END);
                m_busy  = 0;
                m_armed = i_enable;
                if (i_eng_done && ev && roi && i_enable) begin
                    m_busy = 1; m_age = 0; e_start = 1; e_line = lc;
                end else if (!i_eng_done) begin
                    ovr = ev && roi;
                end
            end else begin
                m_age++;
                ovr = ev && roi;
            end
            if (ovr) begin
                e_ovr = 1;
                if (e_cnt < 255) e_cnt++;
            end
            m_prev = lc;
        end
    end

    always @(negedge i_clk) begin
        if (m_valid) begin
            chk("start",   32'(o_eng_start),   32'(e_start));
            chk("line",    32'(o_eng_line),    32'(e_line));
            chk("busy",    32'(o_busy),        32'(m_busy));
            chk("frame",   32'(o_frame_done),  32'(e_frame));
            chk("ovr",     32'(o_overrun),     32'(e_ovr));
            chk("ovr_cnt", 32'(o_overrun_cnt), 32'(e_cnt));
            chk("timeout", 32'(o_timeout),     32'(e_to));
        end
    end

    task automatic tk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_done();
        i_eng_done = 1'b1;
        tk(1);
        i_eng_done = 1'b0;
    endtask

    // Present a new in-window line from ARMED and leave the engine in RUN.
    task automatic launch(input int ln);
        i_line_cnt = LINE_W'(ln);
        tk(1);
        chk("launch_start", 32'(o_eng_start), 32'd1);
        chk("launch_line",  32'(o_eng_line),  32'(ln));
        tk(2);
    endtask

    initial begin
        int n, nl;
        i_resetn = 1'b0; i_enable = 1'b0; i_line_cnt = '0; i_eng_done = 1'b0;
        tk(3);
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_start", 32'(o_eng_start), 32'd0);
        chk("rst_cnt",   32'(o_overrun_cnt), 32'd0);

        // first line of window, done after 50 cycles, then next line
        i_resetn = 1'b1; i_enable = 1'b1; i_line_cnt = 10'd15;
        tk(2);
        i_line_cnt = 10'd16;
        tk(1);
        chk("t1_start", 32'(o_eng_start), 32'd1);
        chk("t1_line",  32'(o_eng_line),  32'd16);
        tk(49);
        pulse_done();
        chk("t1_idle",  32'(o_busy),       32'd0);
        chk("t1_frame", 32'(o_frame_done), 32'd0);
        i_line_cnt = 10'd17;
        tk(1);
        chk("t1_start17", 32'(o_eng_start), 32'd1);
        chk("t1_line17",  32'(o_eng_line),  32'd17);
        tk(2);
        pulse_done();

        // last window line produces frame_done; lines past window are not started
        launch(462); pulse_done();
        launch(463); pulse_done();
        chk("t2_frame", 32'(o_frame_done), 32'd1);
        tk(1);
        chk("t2_frame_off", 32'(o_frame_done), 32'd0);
        i_line_cnt = 10'd464; tk(1);
        chk("t2_no_start464", 32'(o_eng_start), 32'd0);
        i_line_cnt = 10'd0; tk(1);
        chk("t2_no_start0", 32'(o_eng_start), 32'd0);
        tk(2);

        // overrun, dropped line, saturation
        launch(100);
        i_line_cnt = 10'd101; tk(1);
        chk("t3_ovr", 32'(o_overrun), 32'd1);
        chk("t3_cnt", 32'(o_overrun_cnt), 32'd1);
        pulse_done();
        tk(2);
        chk("t3_dropped", 32'(o_busy), 32'd0);
        i_line_cnt = 10'd102; tk(1);
        chk("t3_start102", 32'(o_eng_start), 32'd1);
        chk("t3_line102",  32'(o_eng_line),  32'd102);
        tk(2);
        pulse_done();
        for (int b = 0; b < 15; b++) begin
            launch(20 + b);
            for (int k = 0; k < 20; k++) begin
                i_line_cnt = LINE_W'(300 + (k % 2));
                tk(1);
            end
            pulse_done();
        end
        chk("t3_sat", 32'(o_overrun_cnt), 32'd255);

        // done and new line in the same cycle
        launch(200);
        i_eng_done = 1'b1; i_line_cnt = 10'd201;
        tk(1);
        i_eng_done = 1'b0;
        chk("t4_start", 32'(o_eng_start), 32'd1);
        chk("t4_line",  32'(o_eng_line),  32'd201);
        chk("t4_ovr",   32'(o_overrun),   32'd0);
        tk(2);
        pulse_done();

        // engine timeout
        launch(250);
        n = 0;
        while (o_timeout !== 1'b1 && n < 4 * TMO) begin
            tk(1);
            n++;
        end
        chk("t5_to_lat", 32'(n), 32'(TMO - 1));
        chk("t5_busy",   32'(o_busy), 32'd0);
        tk(1);
        pulse_done();
        chk("t5_late_done", 32'(o_busy), 32'd0);
        chk("t5_no_to",     32'(o_timeout), 32'd0);

        // reset mid-RUN, then enable drop mid-RUN
        launch(300);
        tk(3);
        i_resetn = 1'b0; tk(1);
        chk("t6_rst_busy", 32'(o_busy), 32'd0);
        chk("t6_rst_cnt",  32'(o_overrun_cnt), 32'd0);
        chk("t6_rst_line", 32'(o_eng_line), 32'd0);
        i_resetn = 1'b1;
        tk(2);
        launch(301);
        i_enable = 1'b0;
        tk(3);
        chk("t6_drain", 32'(o_busy), 32'd1);
        pulse_done();
        chk("t6_drained", 32'(o_busy), 32'd0);
        i_line_cnt = 10'd302; tk(1);
        chk("t6_idle_start", 32'(o_eng_start), 32'd0);
        i_enable = 1'b1;
        tk(2);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            i_resetn   = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 49) == 0) i_enable = ~i_enable;
            i_eng_done = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 6))
                    0: nl = int'($urandom_range(0, 524));
                    1: nl = ROI_START - 1;
                    2: nl = ROI_START;
                    3: nl = ROI_END;
                    4: nl = ROI_END + 1;
                    5: nl = 0;
                    default: nl = (int'(i_line_cnt) + 1) % 525;
                endcase
                i_line_cnt = LINE_W'(nl);
            end
            tk(1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
